interrupt_request_ctrl: RTL
===========================

INTERRUPT_REQUEST_CTRL -- requirements
Module: interrupt_request_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops per interrupt pin (legal values 2..3).
REQ-002 SHALL have port clk, input, 1, the single system clock; all flops update on its rising edge.
REQ-003 SHALL have port nrst, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port enableFFs, input, 1, the CPU clock-enable; state advances only when it is high.
REQ-005 SHALL have port nmiPin, input, 1, the raw asynchronous NMI pin, active-low.
REQ-006 SHALL have port irqPin, input, 1, the raw asynchronous IRQ pin, active-low.
REQ-007 SHALL have port processStatusRegIFlag, input, 1, the IRQ mask; 1 means masked.
REQ-008 SHALL have port instructionBoundary, input, 1, high in the cycle the sequencer would fetch the next opcode.
REQ-009 SHALL have port interruptAcknowleged, input, 1, the sequencer accepting the injected interrupt; a one-cycle pulse.
REQ-010 SHALL have port synchronizedNMI, output, 1, the synchronized NMI pin level, active-high.
REQ-011 SHALL have port nmiGenerated, output, 1, a latched NMI edge awaiting injection.
REQ-012 SHALL have port irqGenerated, output, 1, a request issued for an unmasked IRQ.
REQ-013 SHALL have port interruptRequest, output, 1, asking the sequencer to inject an interrupt.
REQ-014 SHALL have port interruptVector, output, 2, the vector select for the requested interrupt: NONE=0, NMI=1, IRQ=2.

Function
REQ-015 SHALL synchronize each pin through SYNC_STAGES flops clocked every clk, regardless of enableFFs, and invert each to active-high.
REQ-016 SHALL detect an NMI edge when synchronizedNMI is 1 and the previous-sample register is 0; the previous-sample register updates only when enableFFs=1.
REQ-017 SHALL set nmiGenerated on a detected edge (enableFFs=1); it holds until interruptAcknowleged=1 while interruptVector=NMI and enableFFs=1.
REQ-018 SHALL give an edge detected in the same cycle as the NMI acknowledge precedence: nmiGenerated stays 1.
REQ-019 SHALL treat IRQ as level-sensitive and not latch it; it is eligible when synchronized IRQ=1 and processStatusRegIFlag=0.
REQ-020 SHALL implement an FSM with states IDLE and REQUEST, advancing only when enableFFs=1.
REQ-021 SHALL move IDLE->REQUEST when instructionBoundary=1 and (nmiGenerated=1 or IRQ is eligible), latching interruptVector with NMI taking priority over IRQ.
REQ-022 SHALL, in REQUEST, hold interruptRequest=1 and keep interruptVector frozen until acknowledge, even if the IRQ deasserts or becomes masked, or a new NMI edge arrives.
REQ-023 SHALL move REQUEST->IDLE on interruptAcknowleged=1, clearing interruptVector to NONE in the same update.
REQ-024 SHALL assert irqGenerated exactly while in REQUEST with interruptVector=IRQ.
REQ-025 SHALL ignore interruptAcknowleged while in IDLE.
REQ-026 SHALL keep an NMI that arrives during REQUEST (IRQ) pending, and inject it at the next boundary after the acknowledge.
REQ-027 SHALL, when enableFFs=0, hold every register except the synchronizers. An NMI pulse shorter than one enabled sample period is not guaranteed to be caught.

Reset
REQ-028 SHALL, when nrst=0 at a rising clk, force all of the following: FSM=IDLE, nmiGenerated=0, interruptRequest=0, irqGenerated=0, interruptVector=NONE.
REQ-029 SHALL also reset the synchronizer flops and the previous-sample register to the pin-inactive value (synchronizedNMI=0).
REQ-030 SHALL abandon any pending or requested interrupt on reset mid-operation; no edge is reported from the pin being low at reset release until it goes high and then low again.

Structure
REQ-031 SHALL take the interruptVector encoding (enum NONE/NMI/IRQ) and the FSM state enum from the shared CPU control package, since the sequencer decodes both.
REQ-032 SHALL instantiate the synchronizer as sub-module pin_synchronizer, parameterized by SYNC_STAGES, once per pin.

Verification
REQ-033 The bench SHALL cover: NMI pin low at cycle 10 with SYNC_STAGES=2 and enableFFs=1 -> synchronizedNMI=1 at cycle 12, nmiGenerated=1 at cycle 13, and no second edge while the pin stays low.
REQ-034 The bench SHALL cover: IRQ low, I=0, boundary pulse -> interruptRequest=1, vector=2, irqGenerated=1; ack -> all return to 0 next cycle.
REQ-035 The bench SHALL cover: IRQ low with I=1 at a boundary -> no request; then I=0 -> request at the next boundary.
REQ-036 The bench SHALL cover: IRQ and NMI both pending at a boundary -> vector=1; after ack, IRQ still low -> vector=2 at the next boundary.
REQ-037 The bench SHALL cover: a new NMI edge in the same cycle as the NMI ack -> nmiGenerated remains 1 and a second NMI request occurs at the next boundary.
REQ-038 The bench SHALL cover: nrst=0 while in REQUEST -> all outputs 0 and vector=0 after one clk; the pin held low through reset release produces no request.

Source files
------------

// File: rtl/interrupt_request_ctrl_pkg.sv
// Shared CPU control types: interrupt vector select and request FSM states.
// The sequencer decodes both, so they live here rather than in the controller.
package interrupt_request_ctrl_pkg;

    typedef enum logic [1:0] {
        VEC_NONE = 2'd0,
        VEC_NMI  = 2'd1,
        VEC_IRQ  = 2'd2
    } int_vector_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_REQUEST = 1'b1
    } req_state_e;

endpackage

// File: rtl/pin_synchronizer.sv
// Multi-flop synchronizer for one active-low asynchronous pin; level is active-high.
// valid rises once the chain holds only post-reset pin samples.
module pin_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic pin_n,
    output logic level,
    output logic valid
);

    logic [SYNC_STAGES-1:0] pipe_q, pipe_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;

    always_comb begin
        pipe_d = {pipe_q[SYNC_STAGES-2:0], pin_n};
        fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            pipe_q <= '1;
            fill_q <= '0;
        end else begin
            pipe_q <= pipe_d;
            fill_q <= fill_d;
        end
    end

    assign level = ~pipe_q[SYNC_STAGES-1];
    assign valid = fill_q[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_request_ctrl.sv
// NMI/IRQ request controller: synchronizes the pins, latches NMI edges and
// presents one frozen interrupt request to the sequencer until acknowledged.
module interrupt_request_ctrl
    import interrupt_request_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       enableFFs,
    input  logic       nmiPin,
    input  logic       irqPin,
    input  logic       processStatusRegIFlag,
    input  logic       instructionBoundary,
    input  logic       interruptAcknowleged,
    output logic       synchronizedNMI,
    output logic       nmiGenerated,
    output logic       irqGenerated,
    output logic       interruptRequest,
    output logic [1:0] interruptVector
);

    logic nmi_sync, nmi_valid, irq_sync, irq_valid;
    logic nmi_prev_q, nmi_prev_d;
    logic nmi_armed_q, nmi_armed_d;
    logic nmi_gen_q, nmi_gen_d;
    logic nmi_edge, nmi_ack, irq_eligible;
    req_state_e  state_q, state_d;
    int_vector_e vector_q, vector_d;

    pin_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk(clk), .nrst(nrst), .pin_n(nmiPin), .level(nmi_sync), .valid(nmi_valid)
    );

    pin_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
        .clk(clk), .nrst(nrst), .pin_n(irqPin), .level(irq_sync), .valid(irq_valid)
    );

    // Edge detection is armed only after a genuine inactive pin sample, so a pin
    // already low at reset release is not mistaken for a fresh edge.
    always_comb begin
        nmi_edge     = nmi_sync & ~nmi_prev_q & nmi_armed_q;
        nmi_ack      = (state_q == ST_REQUEST) && (vector_q == VEC_NMI) && interruptAcknowleged;
        irq_eligible = irq_sync & irq_valid & ~processStatusRegIFlag;
        nmi_prev_d   = nmi_prev_q;
        nmi_armed_d  = nmi_armed_q;
        nmi_gen_d    = nmi_gen_q;
        if (enableFFs) begin
            nmi_prev_d  = nmi_sync;
            nmi_armed_d = nmi_armed_q | (nmi_valid & ~nmi_sync);
            if (nmi_edge) begin
                nmi_gen_d = 1'b1;
            end else if (nmi_ack) begin
                nmi_gen_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            vector_q    <= VEC_NONE;
            nmi_prev_q  <= 1'b0;
            nmi_armed_q <= 1'b0;
            nmi_gen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vector_q    <= vector_d;
            nmi_prev_q  <= nmi_prev_d;
            nmi_armed_q <= nmi_armed_d;
            nmi_gen_q   <= nmi_gen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        if (enableFFs) begin
            case (state_q)
                ST_IDLE: begin
                    if (instructionBoundary && (nmi_gen_q || irq_eligible)) begin
                        state_d  = ST_REQUEST;
                        vector_d = nmi_gen_q ? VEC_NMI : VEC_IRQ;
                    end
                end
                ST_REQUEST: begin
                    if (interruptAcknowleged) begin
                        state_d  = ST_IDLE;
                        vector_d = VEC_NONE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    vector_d = VEC_NONE;
                end
            endcase
        end
    end

    always_comb begin
        synchronizedNMI  = nmi_sync;
        nmiGenerated     = nmi_gen_q;
        interruptRequest = (state_q == ST_REQUEST);
        irqGenerated     = (state_q == ST_REQUEST) && (vector_q == VEC_IRQ);
        interruptVector  = vector_q;
    end

endmodule
